lift_request_queue: RTL and testbench

LIFT_REQUEST_QUEUE -- requirements
Module: lift_request_queue

---
 rtl/lift_request_queue_if.sv | 31 +++
 rtl/lift_request_queue.sv | 176 +++++++++++++++++
 tb/tb_lift_request_queue.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lift_request_queue_if.sv
// Signal bundle between the floor-select panel, the lift controller and the
// request queue. The queue itself connects through the slave modport.
interface lift_request_queue_if;
    logic [8:0] sw;
    logic [3:0] cur_floor;
    logic       ack;
    logic       req_valid;
    logic [3:0] req_floor;
    logic [8:0] pending;
    logic       dir_up;

    modport master (
        output sw,
        output cur_floor,
        output ack,
        input  req_valid,
        input  req_floor,
        input  pending,
        input  dir_up
    );

    modport slave (
        input  sw,
        input  cur_floor,
        input  ack,
        output req_valid,
        output req_floor,
        output pending,
        output dir_up
    );
endinterface

// File: rtl/lift_request_queue.sv
// Lift request queue: synchronises and debounces nine floor switches, keeps a
// pending-floor bitmap and offers the next target using a SCAN-style sweep.
module lift_request_queue #(
    parameter int DEB_CYCLES = 50000
) (
    input logic                  clk,
    input logic                  res,
    lift_request_queue_if.slave  bus
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    logic [8:0] sync1_reg;
    logic [8:0] sync2_reg;
    logic [8:0] deb_vec;
    logic [8:0] deb_d_reg;
    logic [8:0] rise;

    logic [0:0] state_reg;
    logic [0:0] state_next;
    logic [3:0] req_floor_reg;
    logic [3:0] req_floor_next;
    logic       dir_up_reg;
    logic       dir_up_next;
    logic [8:0] pending_reg;
    logic [8:0] pending_next;
    logic [8:0] clr;

    logic [3:0] cf;
    logic [8:0] ge_mask;
    logic [8:0] lt_mask;
    logic [8:0] le_mask;
    logic [8:0] gt_mask;
    logic [3:0] sel_floor;
    logic       sel_dir;

    always_ff @(posedge clk) begin
        if (res) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            deb_d_reg <= '0;
        end else begin
            sync1_reg <= bus.sw;
            sync2_reg <= sync1_reg;
            deb_d_reg <= deb_vec;
        end
    end

    // One counter per switch; the debounced value only moves after
    // DEB_CYCLES consecutive cycles of disagreement.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_deb
            logic [CW-1:0] cnt_reg;
            logic          deb_bit_reg;

            always_ff @(posedge clk) begin
                if (res) begin
                    cnt_reg     <= '0;
                    deb_bit_reg <= 1'b0;
                end else if (sync2_reg[gi] == deb_bit_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
                    cnt_reg     <= '0;
                    deb_bit_reg <= sync2_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign deb_vec[gi] = deb_bit_reg;
        end
    endgenerate

    assign rise = deb_vec & ~deb_d_reg;

    assign cf = (bus.cur_floor > 4'd8) ? 4'd8 : bus.cur_floor;

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_mask
            assign ge_mask[gi] = pending_reg[gi] & (4'(gi) >= cf);
            assign lt_mask[gi] = pending_reg[gi] & (4'(gi) <  cf);
            assign le_mask[gi] = pending_reg[gi] & (4'(gi) <= cf);
            assign gt_mask[gi] = pending_reg[gi] & (4'(gi) >  cf);
        end
    endgenerate

    function automatic logic [3:0] lowest_idx(input logic [8:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] highest_idx(input logic [8:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Keep sweeping in the current direction; reverse only when nothing
    // remains ahead of the car.
    always_comb begin
        sel_floor = 4'd0;
        sel_dir   = dir_up_reg;
        if (dir_up_reg) begin
            if (|ge_mask) begin
                sel_floor = lowest_idx(ge_mask);
                sel_dir   = 1'b1;
            end else begin
                sel_floor = highest_idx(lt_mask);
                sel_dir   = 1'b0;
            end
        end else begin
            if (|le_mask) begin
                sel_floor = highest_idx(le_mask);
                sel_dir   = 1'b0;
            end else begin
                sel_floor = lowest_idx(gt_mask);
                sel_dir   = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        req_floor_next = req_floor_reg;
        dir_up_next    = dir_up_reg;
        clr            = '0;
        case (state_reg)
            IDLE: begin
                if (|pending_reg) begin
                    state_next     = OFFER;
                    req_floor_next = sel_floor;
                    dir_up_next    = sel_dir;
                end
            end
            OFFER: begin
                if (bus.ack) begin
                    clr        = 9'd1 << req_floor_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Clear wins over a same-cycle press: the arriving car serves it.
        pending_next = (pending_reg | rise) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_reg     <= IDLE;
            req_floor_reg <= 4'd0;
            dir_up_reg    <= 1'b1;
            pending_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            req_floor_reg <= req_floor_next;
            dir_up_reg    <= dir_up_next;
            pending_reg   <= pending_next;
        end
    end

    assign bus.req_valid = (state_reg == OFFER);
    assign bus.req_floor = req_floor_reg;
    assign bus.pending   = pending_reg;
    assign bus.dir_up    = dir_up_reg;

endmodule

// File: tb/tb_lift_request_queue.sv
// Directed bench for lift_request_queue with DEB_CYCLES=4: a vector table for
// target selection plus hand-written sequences for timing corner cases.
module tb_lift_request_queue;

    localparam int DEB = 4;

    logic clk;
    logic res;
    int   n_checks;
    int   n_fail;

    lift_request_queue_if bus ();

    lift_request_queue #(.DEB_CYCLES(DEB)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cur;
        logic [8:0] press;
        logic [3:0] exp_floor;
        logic       exp_dir;
        logic [8:0] exp_after;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_offer(input string name);
        int waited;
        waited = 0;
        while (!bus.req_valid && waited < 100) begin
            step();
            waited++;
        end
        check({name, "_offer_timeout"}, {15'd0, bus.req_valid}, 16'd1);
    endtask

    task automatic do_ack(input string name);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check({name, "_valid_after_ack"}, {15'd0, bus.req_valid}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        n_checks = 0;
        n_fail   = 0;

        tbl[0]  = '{4'd3,  9'h092, 4'd4, 1'b1, 9'h082};
        tbl[1]  = '{4'd4,  9'h000, 4'd7, 1'b1, 9'h002};
        tbl[2]  = '{4'd7,  9'h000, 4'd1, 1'b0, 9'h000};
        tbl[3]  = '{4'd1,  9'h021, 4'd0, 1'b0, 9'h020};
        tbl[4]  = '{4'd0,  9'h000, 4'd5, 1'b1, 9'h000};
        tbl[5]  = '{4'd12, 9'h100, 4'd8, 1'b1, 9'h000};
        tbl[6]  = '{4'd8,  9'h044, 4'd6, 1'b0, 9'h004};
        tbl[7]  = '{4'd6,  9'h000, 4'd2, 1'b0, 9'h000};
        tbl[8]  = '{4'd4,  9'h010, 4'd4, 1'b0, 9'h000};
        tbl[9]  = '{4'd5,  9'h108, 4'd3, 1'b0, 9'h100};
        tbl[10] = '{4'd3,  9'h000, 4'd8, 1'b1, 9'h000};
        tbl[11] = '{4'd2,  9'h001, 4'd0, 1'b0, 9'h000};

        // Reset with floor 3 held; the request lands DEB+3 edges after release.
        res           = 1'b1;
        bus.sw        = 9'h008;
        bus.cur_floor = 4'd0;
        bus.ack       = 1'b0;
        repeat (3) step();
        check("rst_req_valid", {15'd0, bus.req_valid}, 16'd0);
        check("rst_req_floor", {12'd0, bus.req_floor}, 16'd0);
        check("rst_pending",   {7'd0, bus.pending},    16'd0);
        check("rst_dir_up",    {15'd0, bus.dir_up},    16'd1);
        res = 1'b0;
        repeat (DEB + 2) step();
        check("hold_rst_early", {7'd0, bus.pending}, 16'd0);
        step();
        check("hold_rst_pending", {7'd0, bus.pending}, 16'h008);
        step();
        check("hold_rst_valid", {15'd0, bus.req_valid}, 16'd1);
        check("hold_rst_floor", {12'd0, bus.req_floor}, 16'd3);
        bus.sw = 9'h000;
        repeat (DEB + 6) step();
        do_ack("hold_rst");
        $display("seq hold_through_reset: floor 3 offered and acknowledged");

        // Short glitch is rejected; a long press is accepted.
        bus.sw = 9'h020;
        repeat (3) step();
        bus.sw = 9'h000;
        repeat (10) step();
        check("glitch_pending", {7'd0, bus.pending}, 16'd0);
        check("glitch_valid", {15'd0, bus.req_valid}, 16'd0);
        bus.sw = 9'h020;
        repeat (7) step();
        check("press5_pending", {7'd0, bus.pending}, 16'h020);
        check("press5_not_yet_valid", {15'd0, bus.req_valid}, 16'd0);
        step();
        check("press5_valid", {15'd0, bus.req_valid}, 16'd1);
        check("press5_floor", {12'd0, bus.req_floor}, 16'd5);
        check("press5_dir", {15'd0, bus.dir_up}, 16'd1);
        bus.sw = 9'h000;
        $display("seq glitch_and_press: floor 5 offered");

        // Long OFFER with a new press arriving; the offer must not move.
        bad = 0;
        bus.sw = 9'h004;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) bus.sw = 9'h000;
            step();
            if (bus.req_valid !== 1'b1 || bus.req_floor !== 4'd5) bad++;
        end
        check("offer_stable_cycles_bad", 16'(bad), 16'd0);
        check("offer_hold_pending", {7'd0, bus.pending}, 16'h024);
        do_ack("offer5");
        check("offer5_pending_after", {7'd0, bus.pending}, 16'h004);
        step();
        check("next_offer_valid", {15'd0, bus.req_valid}, 16'd1);
        check("next_offer_floor", {12'd0, bus.req_floor}, 16'd2);
        do_ack("offer2");
        check("offer2_pending_after", {7'd0, bus.pending}, 16'd0);
        $display("seq long_offer: floor 5 held, then floor 2 offered");

        // Same-cycle press and acknowledge of floor 6: clear wins.
        bus.sw = 9'h040;
        wait_offer("f6");
        check("f6_floor", {12'd0, bus.req_floor}, 16'd6);
        bus.sw = 9'h000;
        repeat (12) step();
        bus.sw = 9'h040;
        repeat (DEB + 2) step();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("f6_clear_wins_pending", {7'd0, bus.pending}, 16'd0);
        check("f6_clear_wins_valid", {15'd0, bus.req_valid}, 16'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.req_valid !== 1'b0) bad++;
        end
        check("f6_no_reoffer", 16'(bad), 16'd0);
        bus.sw = 9'h000;
        repeat (12) step();
        $display("seq set_clear_collision: floor 6 cleared");

        for (int v = 0; v < 12; v++) begin
            bus.cur_floor = tbl[v].cur;
            if (tbl[v].press != 9'h000) begin
                bus.sw = tbl[v].press;
                repeat (DEB + 6) @(posedge clk);
                bus.sw = 9'h000;
                repeat (DEB + 4) @(posedge clk);
                #1;
            end
            wait_offer($sformatf("vec%0d", v));
            check($sformatf("vec%0d_floor", v), {12'd0, bus.req_floor}, {12'd0, tbl[v].exp_floor});
            check($sformatf("vec%0d_dir", v), {15'd0, bus.dir_up}, {15'd0, tbl[v].exp_dir});
            $display("vec %0d: cur_floor=%0d press=%03h -> req_floor=%0d dir_up=%0d",
                     v, tbl[v].cur, tbl[v].press, bus.req_floor, bus.dir_up);
            do_ack($sformatf("vec%0d", v));
            check($sformatf("vec%0d_pending_after", v), {7'd0, bus.pending}, {7'd0, tbl[v].exp_after});
        end

        // Reset during an offer.
        bus.cur_floor = 4'd8;
        bus.sw = 9'h101;
        wait_offer("rst_offer");
        check("rst_offer_floor", {12'd0, bus.req_floor}, 16'd8);
        check("rst_offer_dir", {15'd0, bus.dir_up}, 16'd0);
        check("rst_offer_pending", {7'd0, bus.pending}, 16'h101);
        bus.sw = 9'h000;
        res = 1'b1;
        step();
        res = 1'b0;
        check("mid_rst_valid", {15'd0, bus.req_valid}, 16'd0);
        check("mid_rst_pending", {7'd0, bus.pending}, 16'd0);
        check("mid_rst_dir", {15'd0, bus.dir_up}, 16'd1);
        check("mid_rst_floor", {12'd0, bus.req_floor}, 16'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.req_valid !== 1'b0) bad++;
        end
        check("mid_rst_no_offer", 16'(bad), 16'd0);
        $display("seq reset_during_offer: offer dropped");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
